// File: rtl/l2_arb_pkg.sv
// Shared types and default widths for the L2 port arbiter.
// Optional feature macro: L2_ARB_RR_EN (round-robin tie-break; fixed D priority when undefined).
package l2_arb_pkg;

   localparam int unsigned L2_ADDR_W = 32;
   localparam int unsigned L2_LINE_W = 256;

   typedef enum logic [1:0] {
      s_idle,
      s_serve_i,
      s_serve_d
   } arb_state_t;

   typedef enum logic {
      PORT_I,
      PORT_D
   } arb_port_t;

endpackage

// File: rtl/l2_arb_pick.sv
// Winner selection between the I and D requesters.
// L2_ARB_RR_EN defined: ties go to the port not most recently granted.
// L2_ARB_RR_EN undefined: ties always go to D and no grant history is needed.
module l2_arb_pick
   import l2_arb_pkg::*;
(
   input  logic      i_req,
   input  logic      d_req,
`ifdef L2_ARB_RR_EN
   input  arb_port_t last_grant,
`endif
   output logic      grant_vld,
   output arb_port_t grant_port
);

   // Pick a winner; a lone requester always wins regardless of mode.
   always_comb begin
      grant_vld  = i_req | d_req;
      grant_port = PORT_D;
      if (i_req && !d_req) begin
         grant_port = PORT_I;
      end else if (i_req && d_req) begin
`ifdef L2_ARB_RR_EN
         grant_port = (last_grant == PORT_D) ? PORT_I : PORT_D;
`else
         grant_port = PORT_D;
`endif
      end
   end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares the single L2 port between the L1 I-cache and L1 D-cache.
// A grant covers a whole transaction, from grant until mem_resp.
// Optional feature macro: L2_ARB_RR_EN (round-robin tie-break; fixed D priority when undefined).
module l2_port_arbiter
   import l2_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = L2_ADDR_W,
   parameter int unsigned LINE_W = L2_LINE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_address,
   input  logic [LINE_W-1:0] i_wdata,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   arb_state_t state_q, state_d;
   logic       grant_vld;
   arb_port_t  grant_port;

`ifdef L2_ARB_RR_EN
   arb_port_t  last_grant_q, last_grant_d;
`endif

   l2_arb_pick u_pick (
      .i_req      (i_read | i_write),
      .d_req      (d_read | d_write),
`ifdef L2_ARB_RR_EN
      .last_grant (last_grant_q),
`endif
      .grant_vld  (grant_vld),
      .grant_port (grant_port)
   );

   // Next-state: register the winner from idle, release the port only on mem_resp.
   always_comb begin
      state_d = state_q;
`ifdef L2_ARB_RR_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         s_idle: begin
            if (grant_vld) begin
               state_d = (grant_port == PORT_I) ? s_serve_i : s_serve_d;
`ifdef L2_ARB_RR_EN
               last_grant_d = grant_port;
`endif
            end
         end
         s_serve_i, s_serve_d: begin
            if (mem_resp) state_d = s_idle;
         end
         default: state_d = s_idle;
      endcase
   end

   // Output mux: the owner's strobes pass straight through; write wins over a stray read.
   // Resp is suppressed during reset so a late mem_resp cannot complete an aborted owner.
   always_comb begin
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_address = '0;
      mem_wdata   = '0;
      i_resp      = 1'b0;
      d_resp      = 1'b0;
      case (state_q)
         s_serve_i: begin
            mem_write   = i_write;
            mem_read    = i_read & ~i_write;
            mem_address = i_address;
            mem_wdata   = i_wdata;
            i_resp      = mem_resp & ~rst;
         end
         s_serve_d: begin
            mem_write   = d_write;
            mem_read    = d_read & ~d_write;
            mem_address = d_address;
            mem_wdata   = d_wdata;
            d_resp      = mem_resp & ~rst;
         end
         default: ;
      endcase
   end

   // Read data is broadcast; consumers qualify it with their own resp.
   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;

   // State and grant-history registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= s_idle;
`ifdef L2_ARB_RR_EN
         last_grant_q <= PORT_D;
`endif
      end else begin
         state_q <= state_d;
`ifdef L2_ARB_RR_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter; expectations follow L2_ARB_RR_EN when defined.
module tb_l2_port_arbiter;
   import l2_arb_pkg::*;

   localparam int AW = 32;
   localparam int LW = 256;

`ifdef L2_ARB_RR_EN
   localparam arb_port_t TIE1 = PORT_I;
   localparam arb_port_t TIE2 = PORT_D;
`else
   localparam arb_port_t TIE1 = PORT_D;
   localparam arb_port_t TIE2 = PORT_D;
`endif

   localparam logic [AW-1:0] IA = 32'h0000_1000;
   localparam logic [AW-1:0] DA = 32'h0000_2000;
   localparam logic [LW-1:0] RD_PAT = {8{32'hDEAD_BEEF}};
   localparam logic [LW-1:0] AA_PAT = {32{8'hAA}};
   localparam logic [LW-1:0] I_PAT  = {32{8'h55}};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_read = 1'b0, i_write = 1'b0;
   logic [AW-1:0] i_address = '0;
   logic [LW-1:0] i_wdata = '0;
   logic [LW-1:0] i_rdata;
   logic          i_resp;
   logic          d_read = 1'b0, d_write = 1'b0;
   logic [AW-1:0] d_address = '0;
   logic [LW-1:0] d_wdata = '0;
   logic [LW-1:0] d_rdata;
   logic          d_resp;
   logic          mem_read, mem_write;
   logic [AW-1:0] mem_address;
   logic [LW-1:0] mem_wdata;
   logic [LW-1:0] mem_rdata = '0;
   logic          mem_resp = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   l2_port_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
      .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".mem_read"},    LW'(mem_read),    '0);
      chk({tag, ".mem_write"},   LW'(mem_write),   '0);
      chk({tag, ".mem_address"}, LW'(mem_address), '0);
      chk({tag, ".mem_wdata"},   mem_wdata,        '0);
      chk({tag, ".i_resp"},      LW'(i_resp),      '0);
      chk({tag, ".d_resp"},      LW'(d_resp),      '0);
   endtask

   task automatic expect_grant(input string tag, input logic rd, input logic wr,
                               input logic [AW-1:0] addr, input logic [LW-1:0] wd);
      chk({tag, ".mem_read"},    LW'(mem_read),    LW'(rd));
      chk({tag, ".mem_write"},   LW'(mem_write),   LW'(wr));
      chk({tag, ".mem_address"}, LW'(mem_address), LW'(addr));
      chk({tag, ".mem_wdata"},   mem_wdata,        wd);
      chk({tag, ".i_resp"},      LW'(i_resp),      '0);
      chk({tag, ".d_resp"},      LW'(d_resp),      '0);
   endtask

   task automatic set_req(input arb_port_t p, input logic rd, input logic wr);
      if (p == PORT_I) begin i_read = rd; i_write = wr; end
      else begin d_read = rd; d_write = wr; end
   endtask

   // Pulse mem_resp for the current owner, check the completion, then drop its strobes.
   task automatic finish_txn(input string tag, input arb_port_t p);
      step();
      mem_resp = 1'b1; mem_rdata = RD_PAT;
      smp();
      chk({tag, ".i_resp"},  LW'(i_resp), LW'(p == PORT_I));
      chk({tag, ".d_resp"},  LW'(d_resp), LW'(p == PORT_D));
      chk({tag, ".i_rdata"}, i_rdata, RD_PAT);
      chk({tag, ".d_rdata"}, d_rdata, RD_PAT);
      step();
      mem_resp = 1'b0; mem_rdata = '0;
      set_req(p, 1'b0, 1'b0);
      smp();
      chk_zero({tag, ".turnaround"});
   endtask

   task automatic run_tie(input string tag, input arb_port_t first);
      arb_port_t second;
      second = (first == PORT_I) ? PORT_D : PORT_I;
      step();
      i_read = 1'b1; i_address = IA; i_wdata = I_PAT;
      d_read = 1'b1; d_address = DA; d_wdata = AA_PAT;
      smp();
      chk_zero({tag, ".idle"});
      step(); smp();
      expect_grant({tag, ".first"}, 1'b1, 1'b0, (first == PORT_I) ? IA : DA,
                   (first == PORT_I) ? I_PAT : AA_PAT);
      finish_txn({tag, ".first"}, first);
      step(); smp();
      expect_grant({tag, ".second"}, 1'b1, 1'b0, (second == PORT_I) ? IA : DA,
                   (second == PORT_I) ? I_PAT : AA_PAT);
      finish_txn({tag, ".second"}, second);
   endtask

   // Never both strobes on the downstream port.
   always @(negedge clk) begin
      if (!rst) chk("no_overlap", LW'(mem_read & mem_write), '0);
   end

   // Requesters must not raise read and write together.
   always @(negedge clk) begin
      if (!rst && ((i_read && i_write) || (d_read && d_write)))
         $warning("protocol: read and write asserted together on one port");
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      step(); step();
      smp();
      chk_zero("reset");
      step(); rst = 1'b0;

      // I read 0x1000, 3-cycle L2 latency.
      i_read = 1'b1; i_address = IA; i_wdata = I_PAT;
      smp();
      chk_zero("t1.idle_no_comb");
      step(); smp();
      expect_grant("t1.grant", 1'b1, 1'b0, IA, I_PAT);
      step(); smp();
      expect_grant("t1.wait1", 1'b1, 1'b0, IA, I_PAT);
      step(); smp();
      expect_grant("t1.wait2", 1'b1, 1'b0, IA, I_PAT);
      finish_txn("t1", PORT_I);

      // Fresh reset so grant history starts at D.
      step(); rst = 1'b1;
      step(); rst = 1'b0;
      smp();
      chk_zero("t2.reset");

      run_tie("tie1", TIE1);
      // A lone I transaction leaves I as most recent grant.
      step();
      i_read = 1'b1; i_address = IA;
      step(); smp();
      expect_grant("ionly", 1'b1, 1'b0, IA, I_PAT);
      finish_txn("ionly", PORT_I);
      run_tie("tie2", TIE2);

      // D write while an I read is pending.
      step();
      d_write = 1'b1; d_address = DA; d_wdata = AA_PAT;
      smp();
      chk_zero("dw.idle");
      step();
      i_read = 1'b1; i_address = IA; i_wdata = I_PAT;
      smp();
      expect_grant("dw.grant", 1'b0, 1'b1, DA, AA_PAT);
      step(); smp();
      expect_grant("dw.hold", 1'b0, 1'b1, DA, AA_PAT);
      finish_txn("dw", PORT_D);
      step(); smp();
      expect_grant("dw.then_i", 1'b1, 1'b0, IA, I_PAT);
      finish_txn("dw.i", PORT_I);

      // Owner drops its read before mem_resp; grant stays with D.
      step();
      d_read = 1'b1; d_address = 32'h0000_3000;
      step(); smp();
      expect_grant("drop.grant", 1'b1, 1'b0, 32'h0000_3000, AA_PAT);
      step();
      d_read = 1'b0; i_read = 1'b1; i_address = IA;
      smp();
      expect_grant("drop.held1", 1'b0, 1'b0, 32'h0000_3000, AA_PAT);
      step(); smp();
      expect_grant("drop.held2", 1'b0, 1'b0, 32'h0000_3000, AA_PAT);
      finish_txn("drop", PORT_D);
      step(); smp();
      expect_grant("drop.then_i", 1'b1, 1'b0, IA, I_PAT);
      finish_txn("drop.i", PORT_I);

      // Read and write together on I: write forwarded, read dropped.
      step();
      i_read = 1'b1; i_write = 1'b1; i_address = 32'h0000_4000; i_wdata = AA_PAT;
      step(); smp();
      expect_grant("rw.grant", 1'b0, 1'b1, 32'h0000_4000, AA_PAT);
      finish_txn("rw", PORT_I);

      // Reset in the middle of a D transaction, late mem_resp ignored.
      step();
      d_read = 1'b1; d_address = 32'h0000_5000;
      step(); smp();
      expect_grant("rst.grant", 1'b1, 1'b0, 32'h0000_5000, AA_PAT);
      step(); rst = 1'b1;
      step();
      rst = 1'b0; d_read = 1'b0; mem_resp = 1'b1; mem_rdata = RD_PAT;
      smp();
      chk_zero("rst.after");
      chk("rst.state", LW'(dut.state_q), LW'(s_idle));
      step();
      mem_resp = 1'b0; mem_rdata = '0;
      smp();
      chk_zero("rst.settled");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
